// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline-control constants: Tuse/Tnew encoding and MDU latencies.
// Also sizes the MDU countdown so either latency fits.
package hazard_ctrl_pkg;

  localparam logic [1:0] TUSE_NONE = 2'd3;
  localparam logic [1:0] TNEW_MAX  = 2'd2;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Countdown width: holds the longer latency, never narrower than 4 bits.
  function automatic int md_cnt_width(input int mult_cycles, input int div_cycles);
    int longest;
    int w;
    longest = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
    w = $clog2(longest + 1);
    return (w < 4) ? 4 : w;
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_tracker.sv
// MDU occupancy countdown: loaded on a mult/div start in E, decremented to zero.
// md_busy reflects the registered count and is held low while reset is asserted.
module md_busy_tracker
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic E_md_start,
  input  logic E_md_is_div,
  output logic md_busy
);

  localparam int CW = md_cnt_width(MULT_CYCLES, DIV_CYCLES);

  logic [CW-1:0] md_cnt_q, md_cnt_d;

  // A start while the unit is still counting is dropped rather than restarting it.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (E_md_start && (md_cnt_q == '0)) begin
      md_cnt_d = E_md_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt_q <= '0;
    end else begin
      md_cnt_q <= md_cnt_d;
    end
  end

  assign md_busy = !reset && (md_cnt_q != '0);

  a_no_start_while_busy: assert property (
    @(posedge clk) disable iff (reset) !(E_md_start && (md_cnt_q != '0))
  );

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller: RAW hazards on rs/rt against E and M, plus MDU waits.
// Stall decisions are combinational; only md_busy and stall_cnt come from state.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       D_rs,
  input  logic [4:0]       D_rt,
  input  logic [1:0]       D_tuse_rs,
  input  logic [1:0]       D_tuse_rt,
  input  logic             D_is_md,
  input  logic [4:0]       E_wa,
  input  logic [1:0]       E_tnew,
  input  logic [4:0]       M_wa,
  input  logic [1:0]       M_tnew,
  input  logic             E_md_start,
  input  logic             E_md_is_div,
  output logic             pc_en,
  output logic             fd_en,
  output logic             de_flush,
  output logic             stall,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  logic hit_rs_e, hit_rs_m, hit_rt_e, hit_rt_m;
  logic stall_raw, stall_md;
  logic [CNT_W-1:0] stall_cnt_q;

  md_busy_tracker #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy_tracker (
    .clk         (clk),
    .reset       (reset),
    .E_md_start  (E_md_start),
    .E_md_is_div (E_md_is_div),
    .md_busy     (md_busy)
  );

  // $0 is never a real producer; Tuse of "not used" exceeds any Tnew, so it cannot hit.
  assign hit_rs_e = (D_rs == E_wa) && (E_wa != 5'd0) && (D_tuse_rs < E_tnew);
  assign hit_rs_m = (D_rs == M_wa) && (M_wa != 5'd0) && (D_tuse_rs < M_tnew);
  assign hit_rt_e = (D_rt == E_wa) && (E_wa != 5'd0) && (D_tuse_rt < E_tnew);
  assign hit_rt_m = (D_rt == M_wa) && (M_wa != 5'd0) && (D_tuse_rt < M_tnew);

  assign stall_raw = hit_rs_e || hit_rs_m || hit_rt_e || hit_rt_m;
  assign stall_md  = D_is_md && (md_busy || E_md_start);

  assign stall    = !reset && (stall_raw || stall_md);
  assign pc_en    = !stall;
  assign fd_en    = !stall;
  assign de_flush = stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (stall && !(&stall_cnt_q)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule
